imm_decode_stage: RTL and testbench

Decode-stage front end for the RV32I core. It accepts fetched instructions through a valid/ready handshake and registers them with a two-entry skid buffer. It classifies each opcode into an immediate format and drives the per-field select lines of the immediate extender, aligned with the registered instruction. It also supports pipeline flush and flags illegal opcodes.

---
 rtl/imm_decode_stage_if.sv | 35 +++
 rtl/imm_decode_stage.sv | 149 ++++++++++++++
 tb/tb_imm_decode_stage.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute channel bundle for imm_decode_stage.
// The stage is the slave; the fetch/execute side (or a bench) is the master.
interface imm_decode_stage_if;
   logic        flush_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] inst_i;
   logic [31:0] pc_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic [1:0]  imm0E_o;
   logic [1:0]  imm4_1E_o;
   logic        imm10_5E_o;
   logic [1:0]  imm11E_o;
   logic        imm19_12E_o;
   logic        imm30_20E_o;
   logic [2:0]  fmt_o;
   logic        illegal_o;

   modport slave (
      input  flush_i, in_valid_i, inst_i, pc_i, out_ready_i,
      output in_ready_o, out_valid_o, inst_o, pc_o,
             imm0E_o, imm4_1E_o, imm10_5E_o, imm11E_o, imm19_12E_o, imm30_20E_o,
             fmt_o, illegal_o
   );

   modport master (
      output flush_i, in_valid_i, inst_i, pc_i, out_ready_i,
      input  in_ready_o, out_valid_o, inst_o, pc_o,
             imm0E_o, imm4_1E_o, imm10_5E_o, imm11E_o, imm19_12E_o, imm30_20E_o,
             fmt_o, illegal_o
   );
endinterface

// File: rtl/imm_decode_stage.sv
// RV32I decode-stage front end: two-entry skid buffer that carries each
// instruction together with its immediate-format decode and extender selects.
module imm_decode_stage #(
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input logic              clk_i,
   input logic              rst_i,
   imm_decode_stage_if.slave bus
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   typedef struct packed {
      logic [1:0] imm0;
      logic [1:0] imm4_1;
      logic       imm10_5;
      logic [1:0] imm11;
      logic       imm19_12;
      logic       imm30_20;
   } sel_t;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
      sel_t            sel;
      fmt_e            fmt;
      logic            illegal;
   } entry_t;

   // Extender select pattern for each immediate format (R shares the I pattern)
   function automatic sel_t fmt_sel(input fmt_e f);
      sel_t s;
      case (f)
         FMT_S:   s = '{imm0: 2'd1, imm4_1: 2'd1, imm10_5: 1'b1, imm11: 2'd3, imm19_12: 1'b1, imm30_20: 1'b1};
         FMT_B:   s = '{imm0: 2'd0, imm4_1: 2'd1, imm10_5: 1'b1, imm11: 2'd1, imm19_12: 1'b1, imm30_20: 1'b1};
         FMT_U:   s = '{imm0: 2'd0, imm4_1: 2'd0, imm10_5: 1'b0, imm11: 2'd0, imm19_12: 1'b0, imm30_20: 1'b0};
         FMT_J:   s = '{imm0: 2'd0, imm4_1: 2'd2, imm10_5: 1'b1, imm11: 2'd2, imm19_12: 1'b0, imm30_20: 1'b1};
         default: s = '{imm0: 2'd2, imm4_1: 2'd2, imm10_5: 1'b1, imm11: 2'd3, imm19_12: 1'b1, imm30_20: 1'b1};
      endcase
      return s;
   endfunction

   // Entry shown after reset/flush: the canonical NOP, decoded as a legal I-type
   function automatic entry_t nop_entry(input logic [XLEN-1:0] pc);
      entry_t e;
      e.inst    = NOP_INST;
      e.pc      = pc;
      e.sel     = fmt_sel(FMT_I);
      e.fmt     = FMT_I;
      e.illegal = 1'b0;
      return e;
   endfunction

   entry_t out_q, out_d;
   entry_t skid_q, skid_d;
   logic   out_vld_q, out_vld_d;
   logic   skid_vld_q, skid_vld_d;

   entry_t dec_c;
   logic   accept_c;
   logic   consume_c;

   // Opcode classification of the incoming word
   always_comb begin
      dec_c.inst    = bus.inst_i;
      dec_c.pc      = bus.pc_i;
      dec_c.fmt     = FMT_I;
      dec_c.illegal = 1'b0;
      case (bus.inst_i[6:0])
         7'b0110111, 7'b0010111: dec_c.fmt = FMT_U;
         7'b1101111:             dec_c.fmt = FMT_J;
         7'b1100111, 7'b0000011, 7'b0010011,
         7'b0001111, 7'b1110011: dec_c.fmt = FMT_I;
         7'b0100011:             dec_c.fmt = FMT_S;
         7'b1100011:             dec_c.fmt = FMT_B;
         7'b0110011:             dec_c.fmt = FMT_R;
         default:                dec_c.illegal = 1'b1;
      endcase
      dec_c.sel = fmt_sel(dec_c.fmt);
   end

   // Skid-buffer next state; SKID is only ever valid while OUT is valid
   always_comb begin
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      accept_c   = bus.in_valid_i & ~skid_vld_q;
      consume_c  = out_vld_q & bus.out_ready_i;

      if (bus.flush_i) begin
         out_d      = nop_entry(out_q.pc);
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end else if (skid_vld_q) begin
         if (consume_c) begin
            out_d      = skid_q;
            skid_vld_d = 1'b0;
         end
      end else if (accept_c) begin
         if (!out_vld_q || consume_c) begin
            out_d     = dec_c;
            out_vld_d = 1'b1;
         end else begin
            skid_d     = dec_c;
            skid_vld_d = 1'b1;
         end
      end else if (consume_c) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q      <= nop_entry('0);
         skid_q     <= nop_entry('0);
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         out_q      <= out_d;
         skid_q     <= skid_d;
         out_vld_q  <= out_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign bus.in_ready_o  = ~skid_vld_q;
   assign bus.out_valid_o = out_vld_q;
   assign bus.inst_o      = out_q.inst;
   assign bus.pc_o        = out_q.pc;
   assign bus.imm0E_o     = out_q.sel.imm0;
   assign bus.imm4_1E_o   = out_q.sel.imm4_1;
   assign bus.imm10_5E_o  = out_q.sel.imm10_5;
   assign bus.imm11E_o    = out_q.sel.imm11;
   assign bus.imm19_12E_o = out_q.sel.imm19_12;
   assign bus.imm30_20E_o = out_q.sel.imm30_20;
   assign bus.fmt_o       = 3'(out_q.fmt);
   assign bus.illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: FIFO-level reference model checked every cycle,
// plus directed scenarios with hand-computed immediates and handshake values.
module tb_imm_decode_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imm_decode_stage_if bus ();

   imm_decode_stage #(.NOP_INST(NOP)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   ent_t q[$];
   ent_t hold;
   bit   armed = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] exp_fmt(input logic [31:0] i);
      case (i[6:0])
         7'b0110111, 7'b0010111: return 3'd4;
         7'b1101111:             return 3'd5;
         7'b0100011:             return 3'd2;
         7'b1100011:             return 3'd3;
         7'b0110011:             return 3'd0;
         default:                return 3'd1;
      endcase
   endfunction

   function automatic logic exp_ill(input logic [31:0] i);
      case (i[6:0])
         7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0010011,
         7'b0001111, 7'b1110011, 7'b0100011, 7'b1100011, 7'b0110011: return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   // {imm0,imm4_1,imm10_5,imm11,imm19_12,imm30_20} per format
   function automatic logic [8:0] exp_sel(input logic [2:0] f);
      case (f)
         3'd2:    return {2'd1, 2'd1, 1'b1, 2'd3, 1'b1, 1'b1};
         3'd3:    return {2'd0, 2'd1, 1'b1, 2'd1, 1'b1, 1'b1};
         3'd4:    return {2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0};
         3'd5:    return {2'd0, 2'd2, 1'b1, 2'd2, 1'b0, 1'b1};
         default: return {2'd2, 2'd2, 1'b1, 2'd3, 1'b1, 1'b1};
      endcase
   endfunction

   // Architectural immediate straight from the ISA bit layouts
   function automatic logic [31:0] exp_imm(input logic [31:0] i);
      case (exp_fmt(i))
         3'd2:    return {{20{i[31]}}, i[31:25], i[11:7]};
         3'd3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'd4:    return {i[31:12], 12'h000};
         3'd5:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default: return {{20{i[31]}}, i[31:20]};
      endcase
   endfunction

   // Behaviour of the downstream extender given the select lines
   function automatic logic [31:0] extend(input logic [31:0] i, input logic [8:0] s);
      logic [31:0] r;
      r[31] = i[31];
      case (s[8:7])
         2'd1:    r[0] = i[7];
         2'd2:    r[0] = i[20];
         default: r[0] = 1'b0;
      endcase
      case (s[6:5])
         2'd1:    r[4:1] = i[11:8];
         2'd2:    r[4:1] = i[24:21];
         default: r[4:1] = 4'h0;
      endcase
      r[10:5] = s[4] ? i[30:25] : 6'h00;
      case (s[3:2])
         2'd1:    r[11] = i[7];
         2'd2:    r[11] = i[20];
         2'd3:    r[11] = i[31];
         default: r[11] = 1'b0;
      endcase
      r[19:12] = s[1] ? {8{i[31]}} : i[19:12];
      r[30:20] = s[0] ? {11{i[31]}} : i[30:20];
      return r;
   endfunction

   function automatic logic [8:0] dut_sel();
      return {bus.imm0E_o, bus.imm4_1E_o, bus.imm10_5E_o, bus.imm11E_o,
              bus.imm19_12E_o, bus.imm30_20E_o};
   endfunction

   // Reference: a two-deep FIFO; the front (or last shown entry) is on the output
   always @(posedge clk) begin
      ent_t disp;
      ent_t e;
      bit   cons;
      bit   acc;
      disp = (q.size() > 0) ? q[0] : hold;
      if (rst) begin
         q.delete();
         hold.inst = NOP;
         hold.pc   = 32'h0;
         armed     = 1'b1;
      end else if (bus.flush_i) begin
         q.delete();
         hold.inst = NOP;
         hold.pc   = disp.pc;
      end else begin
         cons = (q.size() > 0) && bus.out_ready_i;
         acc  = bus.in_valid_i && (q.size() < 2);
         if (cons) hold = q.pop_front();
         if (acc) begin
            e.inst = bus.inst_i;
            e.pc   = bus.pc_i;
            q.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      ent_t d;
      if (armed) begin
         d = (q.size() > 0) ? q[0] : hold;
         chk("out_valid", 32'(bus.out_valid_o), 32'(q.size() > 0));
         chk("in_ready", 32'(bus.in_ready_o), 32'(q.size() < 2));
         chk("inst_o", bus.inst_o, d.inst);
         chk("pc_o", bus.pc_o, d.pc);
         chk("fmt_o", 32'(bus.fmt_o), 32'(exp_fmt(d.inst)));
         chk("illegal_o", 32'(bus.illegal_o), 32'(exp_ill(d.inst)));
         chk("selects", 32'(dut_sel()), 32'(exp_sel(exp_fmt(d.inst))));
         chk("ext_imm", extend(bus.inst_o, dut_sel()), exp_imm(d.inst));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
      bus.in_valid_i = v;
      bus.inst_i     = i;
      bus.pc_i       = p;
   endtask

   logic [31:0] tab [12];
   int          idx;
   bit          acc_now;

   initial begin
      tab = '{32'h00A00513, 32'h00B52023, 32'hFEB51CE3, 32'hABCDE537,
              32'h00001517, 32'h008000EF, 32'h000500E7, 32'h00052583,
              32'h40B50533, 32'h0000000F, 32'h00000073, 32'h12345678};
      bus.flush_i     = 1'b0;
      bus.out_ready_i = 1'b1;
      drive(1'b0, 32'h0, 32'h0);

      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
      chk("rst_inst", bus.inst_o, 32'h0000_0013);
      chk("rst_fmt", 32'(bus.fmt_o), 32'd1);
      chk("rst_pc", bus.pc_o, 32'h0);

      drive(1'b1, 32'hFFF00093, 32'h100);
      tick();
      chk("addi_valid", 32'(bus.out_valid_o), 32'd1);
      chk("addi_fmt", 32'(bus.fmt_o), 32'd1);
      chk("addi_sel", 32'(dut_sel()), 32'(9'b10_10_1_11_1_1));
      chk("addi_imm", extend(bus.inst_o, dut_sel()), 32'hFFFFFFFF);

      drive(1'b1, 32'hFE000EE3, 32'h104);
      tick();
      chk("beq_fmt", 32'(bus.fmt_o), 32'd3);
      chk("beq_sel", 32'(dut_sel()), 32'(9'b00_01_1_01_1_1));
      chk("beq_imm", extend(bus.inst_o, dut_sel()), 32'hFFFFFFFC);

      drive(1'b0, 32'h0, 32'h0);
      tick();
      chk("drain_valid", 32'(bus.out_valid_o), 32'd0);

      // Backpressure: LUI lands in OUT, JAL in SKID
      bus.out_ready_i = 1'b0;
      drive(1'b1, 32'h123450B7, 32'h108);
      tick();
      chk("bp_ready1", 32'(bus.in_ready_o), 32'd1);
      drive(1'b1, 32'h0000006F, 32'h10C);
      tick();
      chk("bp_ready_low", 32'(bus.in_ready_o), 32'd0);
      chk("bp_lui_held", bus.inst_o, 32'h123450B7);
      drive(1'b0, 32'h0, 32'h0);
      tick();
      chk("bp_stall_inst", bus.inst_o, 32'h123450B7);
      chk("bp_lui_fmt", 32'(bus.fmt_o), 32'd4);
      chk("bp_lui_imm", extend(bus.inst_o, dut_sel()), 32'h12345000);
      bus.out_ready_i = 1'b1;
      tick();
      chk("bp_jal_inst", bus.inst_o, 32'h0000006F);
      chk("bp_jal_fmt", 32'(bus.fmt_o), 32'd5);
      chk("bp_ready_high", 32'(bus.in_ready_o), 32'd1);
      tick();
      chk("bp_empty", 32'(bus.out_valid_o), 32'd0);

      // Flush with both entries full and a new input presented
      bus.out_ready_i = 1'b0;
      drive(1'b1, 32'h00112223, 32'h200);
      tick();
      drive(1'b1, 32'h002081B3, 32'h204);
      tick();
      bus.flush_i = 1'b1;
      drive(1'b1, 32'h00500113, 32'h208);
      tick();
      bus.flush_i = 1'b0;
      chk("fl_valid", 32'(bus.out_valid_o), 32'd0);
      chk("fl_ready", 32'(bus.in_ready_o), 32'd1);
      chk("fl_inst", bus.inst_o, 32'h0000_0013);
      chk("fl_fmt", 32'(bus.fmt_o), 32'd1);
      drive(1'b0, 32'h0, 32'h0);
      bus.out_ready_i = 1'b1;
      tick();
      chk("fl_dropped", 32'(bus.out_valid_o), 32'd0);

      // Illegal opcodes
      drive(1'b1, 32'h0000007F, 32'h300);
      tick();
      chk("ill7f_flag", 32'(bus.illegal_o), 32'd1);
      chk("ill7f_fmt", 32'(bus.fmt_o), 32'd1);
      chk("ill7f_valid", 32'(bus.out_valid_o), 32'd1);
      drive(1'b1, 32'h00000000, 32'h304);
      tick();
      chk("ill00_flag", 32'(bus.illegal_o), 32'd1);
      chk("ill00_fmt", 32'(bus.fmt_o), 32'd1);
      drive(1'b0, 32'h0, 32'h0);
      tick();

      // Streaming with intermittent backpressure; model tracks ordering
      idx = 0;
      for (int c = 0; c < 80 && idx < 12; c++) begin
         drive(1'b1, tab[idx], 32'h400 + 32'(idx) * 32'd4);
         bus.out_ready_i = ((c % 3) != 1);
         acc_now = bus.in_ready_o;
         tick();
         if (acc_now) idx++;
      end
      chk("burst_all_sent", 32'(idx), 32'd12);
      drive(1'b0, 32'h0, 32'h0);
      bus.out_ready_i = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      chk("burst_drained", 32'(bus.out_valid_o), 32'd0);

      // Reset while stalled with both entries full
      bus.out_ready_i = 1'b0;
      drive(1'b1, 32'h00A00513, 32'h500);
      tick();
      drive(1'b1, 32'h00B52023, 32'h504);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rs_valid", 32'(bus.out_valid_o), 32'd0);
      chk("rs_ready", 32'(bus.in_ready_o), 32'd1);
      chk("rs_pc", bus.pc_o, 32'h0);
      chk("rs_inst", bus.inst_o, 32'h0000_0013);
      bus.out_ready_i = 1'b1;
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
